// File: rtl/periph_bridge_pkg.sv
// Shared types for the multi-master OBI to reg-bus bridge.
package periph_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int RULE_AW         = 32;

  // One address window; the system concatenates these into rule_base_i / rule_end_i.
  typedef struct packed {
    logic [RULE_AW-1:0] base;
    logic [RULE_AW-1:0] end_addr;
  } rule_t;

endpackage

// File: rtl/periph_rr_arb.sv
// Combinational round-robin arbiter: first requester strictly after ptr_i wins.
module periph_rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    int k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = N; off >= 1; off--) begin
      k = (int'(ptr_i) + off) % N;
      if (req_i[k]) begin
        idx_o = IW'(k);
        any_o = 1'b1;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/periph_multi_bridge.sv
// Multi-master OBI to reg-bus bridge with range decode, timeout and error response.
module periph_multi_bridge
  import periph_bridge_pkg::*;
#(
  parameter int NMASTERS = 3,
  parameter int NPERIPH  = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NMASTERS-1:0]    m_req_i,
  input  logic [NMASTERS*AW-1:0] m_addr_i,
  input  logic [NMASTERS-1:0]    m_we_i,
  input  logic [NMASTERS*DW/8-1:0] m_be_i,
  input  logic [NMASTERS*DW-1:0] m_wdata_i,
  output logic [NMASTERS-1:0]    m_gnt_o,
  output logic [NMASTERS-1:0]    m_rvalid_o,
  output logic [DW-1:0]          m_rdata_o,
  output logic                   m_err_o,
  input  logic [NPERIPH*AW-1:0]  rule_base_i,
  input  logic [NPERIPH*AW-1:0]  rule_end_i,
  output logic [NPERIPH-1:0]     p_valid_o,
  output logic [AW-1:0]          p_addr_o,
  output logic                   p_write_o,
  output logic [DW-1:0]          p_wdata_o,
  output logic [DW/8-1:0]        p_wstrb_o,
  input  logic [NPERIPH*DW-1:0]  p_rdata_i,
  input  logic [NPERIPH-1:0]     p_ready_i,
  input  logic [NPERIPH-1:0]     p_error_i
);

  localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int PW = (NPERIPH > 1) ? $clog2(NPERIPH) : 1;
  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  logic [MW-1:0]        ptr_q, ptr_d;     // also the owner of the in-flight transaction
  logic [PW-1:0]        sel_q, sel_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic [BW-1:0]        be_q, be_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NPERIPH-1:0]   p_valid_q, p_valid_d;
  logic [NMASTERS-1:0]  rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NMASTERS-1:0]  arb_gnt;
  logic [MW-1:0]        arb_idx;
  logic                 arb_any;

  logic [AW-1:0]        g_addr;
  logic                 g_we;
  logic [BW-1:0]        g_be;
  logic [DW-1:0]        g_wdata;
  logic                 hit;
  logic [PW-1:0]        hit_idx;

  periph_rr_arb #(.N(NMASTERS), .IW(MW)) u_arb (
    .req_i (m_req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Select the winning master's request fields.
  always_comb begin
    int gi;
    gi      = int'(arb_idx);
    g_addr  = m_addr_i[gi*AW +: AW];
    g_we    = m_we_i[gi];
    g_be    = m_be_i[gi*BW +: BW];
    g_wdata = m_wdata_i[gi*DW +: DW];
  end

  // Range decode; disabled rules (end <= base) never hit, lowest index wins.
  always_comb begin
    logic [AW-1:0] rb, re;
    hit     = 1'b0;
    hit_idx = '0;
    rb      = '0;
    re      = '0;
    for (int i = NPERIPH - 1; i >= 0; i--) begin
      rb = rule_base_i[i*AW +: AW];
      re = rule_end_i[i*AW +: AW];
      if (re > rb && g_addr >= rb && g_addr < re) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Next-state logic for the IDLE -> ACCESS -> RESP transaction sequence.
  always_comb begin
    int si;
    si        = int'(sel_q);
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    p_valid_d = p_valid_q;
    rvalid_d  = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          ptr_d   = arb_idx;
          addr_d  = g_addr;
          we_d    = g_we;
          be_d    = g_be;
          wdata_d = g_wdata;
          if (hit) begin
            sel_d              = hit_idx;
            p_valid_d          = '0;
            p_valid_d[hit_idx] = 1'b1;
            state_d            = ACCESS;
          end else begin
            rvalid_d = arb_gnt;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ACCESS: begin
        if (p_ready_i[si]) begin
          p_valid_d       = '0;
          cnt_d           = '0;
          rdata_d         = we_q ? '0 : p_rdata_i[si*DW +: DW];
          err_d           = p_error_i[si];
          rvalid_d[ptr_q] = 1'b1;
          state_d         = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          p_valid_d       = '0;
          cnt_d           = '0;
          err_d           = 1'b1;
          rvalid_d[ptr_q] = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= MW'(NMASTERS - 1);
      sel_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      p_valid_q <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      p_valid_q <= p_valid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Grant is combinational in IDLE; held off while reset is asserted.
  assign m_gnt_o    = (state_q == IDLE && !rst_i) ? arb_gnt : '0;
  assign m_rvalid_o = rvalid_q;
  assign m_rdata_o  = rdata_q;
  assign m_err_o    = err_q;
  assign p_valid_o  = p_valid_q;
  assign p_addr_o   = addr_q;
  assign p_write_o  = we_q;
  assign p_wdata_o  = wdata_q;
  assign p_wstrb_o  = we_q ? be_q : '0;

endmodule

// File: doc/periph_multi_bridge.md
Name: periph_multi_bridge

Overview:
- Multi-master OBI to register-bus bridge for the peripheral subsystem. It is the parametrised successor of the single-port bridge-plus-demux peripheral block.
- Accepts requests from NMASTERS OBI masters (one per hart) and arbitrates between them round-robin.
- Decodes each address against NPERIPH runtime-programmable ranges and drives one reg-bus target at a time.
- Returns an error response for unmapped addresses, for target-signalled errors, and for targets that stall past TIMEOUT cycles.

Parameters:
- NMASTERS, 3, number of OBI master ports (≥1).
- NPERIPH, 4, number of reg-bus target ports (≥1).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- TIMEOUT, 255, maximum ACCESS cycles without p_ready_i before abort (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_req_i  in  NMASTERS  per-master request.
- m_addr_i  in  NMASTERS*AW  per-master address, master k at slice [k*AW +: AW].
- m_we_i  in  NMASTERS  1 = write.
- m_be_i  in  NMASTERS*DW/8  byte enables.
- m_wdata_i  in  NMASTERS*DW  write data.
- m_gnt_o  out  NMASTERS  one-hot grant.
- m_rvalid_o  out  NMASTERS  one-hot response valid.
- m_rdata_o  out  DW  response data, shared by all masters; qualified by m_rvalid_o.
- m_err_o  out  1  response error, qualified by m_rvalid_o.
- rule_base_i  in  NPERIPH*AW  range start per target, inclusive.
- rule_end_i  in  NPERIPH*AW  range end per target, exclusive.
- p_valid_o  out  NPERIPH  one-hot target select.
- p_addr_o  out  AW  target address, raw and not rebased.
- p_write_o  out  1  write strobe.
- p_wdata_o  out  DW  write data.
- p_wstrb_o  out  DW/8  byte strobes.
- p_rdata_i  in  NPERIPH*DW  per-target read data.
- p_ready_i  in  NPERIPH  per-target ready.
- p_error_i  in  NPERIPH  per-target error, sampled with ready.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - rst_i is synchronous and active-high; it takes effect only on a rising edge of clk_i.
- Reset state:
  - FSM returns to IDLE.
  - All outputs are 0: m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, p_valid_o, p_addr_o, p_write_o, p_wdata_o, p_wstrb_o.
  - Round-robin pointer = NMASTERS-1, so master 0 wins first.
  - Timeout counter = 0.
- Reset mid-transaction: the transaction is dropped silently; no rvalid is ever produced for it.
- FSM states: IDLE, ACCESS, RESP. At most one transaction is in flight.
- IDLE:
  - If any m_req_i is set, grant the first requester strictly after the pointer, wrapping modulo NMASTERS.
  - m_gnt_o is combinational and asserted in the same cycle.
  - On that edge: latch addr, we, be and wdata; update pointer to the granted index; decode the address.
  - Decode rule: target i hits when rule_base ≤ addr < rule_end. A rule with end ≤ base is disabled. The lowest matching index wins.
  - Hit: go to ACCESS with p_valid_o[i] = 1 registered.
  - Miss: go to RESP with err = 1 and rdata = 0; no p_valid_o pulse occurs.
- ACCESS:
  - p_valid_o, p_addr_o, p_write_o, p_wdata_o and p_wstrb_o are held stable.
  - p_wstrb_o = be when writing, 0 when reading.
  - Counter increments each cycle.
  - If p_ready_i[i] = 1: latch rdata (forced to 0 on writes) and err = p_error_i[i], drop p_valid_o, go to RESP.
  - Else if counter == TIMEOUT-1: drop p_valid_o, err = 1, rdata = 0, go to RESP.
  - Ready wins if it coincides with the timeout cycle.
  - Counter clears on exit.
- RESP:
  - m_rvalid_o[granted] = 1 for exactly one cycle, together with m_rdata_o and m_err_o.
  - Next state is IDLE. No grant is issued in RESP.
  - m_rdata_o and m_err_o return to 0 outside RESP.
- Latency:
  - Hit, target ready in first ACCESS cycle: grant at cycle 0, p_valid at cycle 1, rvalid at cycle 2.
  - Decode miss: rvalid at cycle 1.
  - Minimum spacing between grants is 3 cycles for hits.
- A master holding m_req_i across a transaction is re-arbitrated fairly against the others; with all masters requesting, grants rotate 0, 1, 2, 0, …
- Rule inputs are sampled only in IDLE on the grant edge; changing them mid-transaction has no effect on that transaction.

Decomposition:
- Package periph_bridge_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the default TIMEOUT localparam;
  - a rule_t struct {base, end_addr}, used by the integrating system to build rule_base_i and rule_end_i.
- Sub-module periph_rr_arb holds the parametrised round-robin arbiter.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Read hit: rule0 = [0x1000, 0x2000); master 0 reads 0x1004; target 0 ready in cycle 1 with rdata 0xDEADBEEF -> gnt0 @0, p_valid_o = 0001 @1, m_rvalid_o = 001 with rdata 0xDEADBEEF and err = 0 @2.
- Write: master 2 writes 0x1008, wdata 0xA5A5A5A5, be 0011 -> p_write_o = 1, p_wstrb_o = 0011, p_wdata_o = 0xA5A5A5A5 stable until ready; rvalid at master 2 with rdata 0.
- Decode miss: read 0x9000 with no matching rule -> no p_valid_o pulse; rvalid @1 with err = 1, rdata 0.
- Fairness: all three masters hold req continuously for 6 transactions -> grant order 0, 1, 2, 0, 1, 2.
- Timeout: TIMEOUT = 4 and target never ready -> p_valid_o high exactly 4 cycles, then rvalid with err = 1; separately, ready in the 4th cycle -> err = p_error_i and data returned.
- Overlap and reset: rule0 = [0x0, 0x2000), rule1 = [0x1000, 0x3000); access 0x1800 -> target 0. Asserting rst_i during ACCESS -> all outputs 0 next cycle and no rvalid for that transaction.
